// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sizes, index widths and loader FSM states for the sprite loader
package sprite_pkg;
  localparam int SPRITE_W_DEFAULT = 32;
  localparam int SPRITE_H_DEFAULT = 32;
  localparam int COL_W = $clog2(SPRITE_W_DEFAULT);
  localparam int ROW_W = $clog2(SPRITE_H_DEFAULT);
  typedef enum logic {LOAD, PENDING} loader_state_t;
endpackage

// File: rtl/vsync_fall_sync.sv
// vsync_fall_sync: two-flop vsync synchronizer with a registered one-cycle falling-edge pulse
module vsync_fall_sync (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic vs_fall
);
  logic s1, s2, s3;
  // sync flops reset high so the first sampled low is a real edge
  always_ff @(posedge clk or negedge reset)
    if (!reset) {s1, s2, s3, vs_fall} <= 4'b1110;
    else begin
      s1 <= vsync;
      s2 <= s1;
      s3 <= s2;
      vs_fall <= s3 & ~s2;
    end
endmodule

// File: rtl/sprite_bitmap_loader.sv
// sprite_bitmap_loader: double-buffered 1-bit sprite store, shadow bank swapped in on vsync fall
// Optional horizontal flip under SPRITE_LOADER_MIRROR_EN.
module sprite_bitmap_loader
  import sprite_pkg::*;
#(
  parameter int SPRITE_W = SPRITE_W_DEFAULT,
  parameter int SPRITE_H = SPRITE_H_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        vsync,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [$clog2(SPRITE_H)-1:0] wr_row,
  input  logic [SPRITE_W-1:0]         wr_data,
  input  logic                        wr_last,
  input  logic [$clog2(SPRITE_W)-1:0] rd_col,
  input  logic [$clog2(SPRITE_H)-1:0] rd_row,
`ifdef SPRITE_LOADER_MIRROR_EN
  input  logic                        mirror,
`endif
  output logic                        rd_pixel,
  output logic                        image_valid,
  output logic                        swap_pulse,
  output logic                        partial
);
  localparam int CW = $clog2(SPRITE_W);
  logic [SPRITE_W-1:0] mem [2][SPRITE_H];
  loader_state_t state, state_n;
  logic [SPRITE_H-1:0] mask, mask_n, wr_hit;
  logic active_sel, vs_fall, accept, do_swap, partial_n;
  logic [CW-1:0] col;
  vsync_fall_sync u_sync (.clk(clk), .reset(reset), .vsync(vsync), .vs_fall(vs_fall));
  assign wr_ready = state == LOAD;
  always_comb begin
    accept = wr_valid && wr_ready;
    wr_hit = accept ? SPRITE_H'(1) << wr_row : '0;
    do_swap = state == PENDING && vs_fall;
    state_n = do_swap ? LOAD : (accept && wr_last) ? PENDING : state;
    mask_n = do_swap ? '0 : mask | wr_hit;
    partial_n = accept && wr_last && !(&(mask | wr_hit));
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= LOAD;
      mask <= '0;
      active_sel <= 1'b0;
      image_valid <= 1'b0;
      swap_pulse <= 1'b0;
      partial <= 1'b0;
    end else begin
      state <= state_n;
      mask <= mask_n;
      active_sel <= active_sel ^ do_swap;
      image_valid <= image_valid | do_swap;
      swap_pulse <= do_swap;
      partial <= partial_n;
    end
  always_ff @(posedge clk)
    if (accept) mem[!active_sel][wr_row] <= wr_data;
`ifdef SPRITE_LOADER_MIRROR_EN
  logic mirror_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) mirror_q <= 1'b0;
    else if (vs_fall) mirror_q <= mirror;
  assign col = mirror_q ? ~rd_col : rd_col;
`else
  assign col = rd_col;
`endif
  // column 0 lives in the MSB, so the bit index is the complemented column
  always_ff @(posedge clk or negedge reset)
    if (!reset) rd_pixel <= 1'b0;
    else rd_pixel <= image_valid && mem[active_sel][rd_row][~col];
endmodule

// File: tb/tb_sprite_bitmap_loader.sv
// tb_sprite_bitmap_loader: directed self-checking bench for sprite_bitmap_loader
module tb_sprite_bitmap_loader;
  logic clk = 0, reset = 0, vsync = 1, wr_valid = 0, wr_last = 0;
  logic [4:0] wr_row = 0, rd_row = 0, rd_col = 0;
  logic [31:0] wr_data = 0;
  logic wr_ready, rd_pixel, image_valid, swap_pulse, partial;
  int total = 0, bad = 0;
`ifdef SPRITE_LOADER_MIRROR_EN
  logic mirror = 0;
`endif

  sprite_bitmap_loader dut (
    .clk(clk), .reset(reset), .vsync(vsync), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_row(wr_row), .wr_data(wr_data), .wr_last(wr_last), .rd_col(rd_col), .rd_row(rd_row),
`ifdef SPRITE_LOADER_MIRROR_EN
    .mirror(mirror),
`endif
    .rd_pixel(rd_pixel), .image_valid(image_valid), .swap_pulse(swap_pulse), .partial(partial)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] row, input logic [31:0] data, input logic last);
    wr_valid = 1; wr_row = row; wr_data = data; wr_last = last;
    step();
    wr_valid = 0; wr_last = 0;
  endtask

  task automatic load(input int first, input int last_row, input logic [31:0] data, input logic do_last);
    for (int r = first; r <= last_row; r++) wr(5'(r), data, do_last && r == last_row);
  endtask

  task automatic rd(input string tag, input logic [4:0] row, input logic [4:0] col, input logic exp);
    rd_row = row; rd_col = col;
    step();
    chk(tag, {31'd0, rd_pixel}, {31'd0, exp});
  endtask

  // vsync fall must produce swap_pulse on the 4th edge: 3 sync/edge flops, then the swap register
  task automatic vfall(input string tag);
    int n = 0;
    vsync = 0;
    while (!swap_pulse && n < 8) begin
      step();
      n++;
    end
    chk({tag, "_swap_edges"}, n, 4);
    chk({tag, "_ready_after_swap"}, {31'd0, wr_ready}, 1);
    chk({tag, "_image_valid"}, {31'd0, image_valid}, 1);
    step();
    chk({tag, "_swap_one_cycle"}, {31'd0, swap_pulse}, 0);
    vsync = 1;
    repeat (4) step();
  endtask

  initial begin
    repeat (2) step();
    reset = 1;
    step();
    chk("rst_ready", {31'd0, wr_ready}, 1);
    chk("rst_image_valid", {31'd0, image_valid}, 0);
    chk("rst_swap", {31'd0, swap_pulse}, 0);
    chk("rst_partial", {31'd0, partial}, 0);
    chk("rst_pixel", {31'd0, rd_pixel}, 0);
    rd("rd_before_image", 5'd5, 5'd0, 1'b0);

    load(0, 31, 32'h8000_0001, 1'b1);
    chk("ready_low_after_last", {31'd0, wr_ready}, 0);
    chk("full_no_partial", {31'd0, partial}, 0);
    repeat (3) step();
    chk("ready_low_pending", {31'd0, wr_ready}, 0);
    chk("no_swap_without_vsync", {31'd0, swap_pulse}, 0);
    vfall("img1");
    rd("img1_c0", 5'd5, 5'd0, 1'b1);
    rd("img1_c31", 5'd5, 5'd31, 1'b1);
    rd("img1_c16", 5'd5, 5'd16, 1'b0);

    load(0, 31, 32'hFFFF_0000, 1'b1);
    rd("b_hidden_c1", 5'd5, 5'd1, 1'b0);
    rd("b_hidden_c31", 5'd5, 5'd31, 1'b1);
    vfall("imgb");
    rd("b_shown_c1", 5'd5, 5'd1, 1'b1);
    rd("b_shown_c31", 5'd5, 5'd31, 1'b0);

    load(0, 30, 32'h0F0F_0F0F, 1'b0);
    vsync = 0;
    repeat (3) step();
    wr(5'd31, 32'h0F0F_0F0F, 1'b1);
    chk("coincide_no_swap", {31'd0, swap_pulse}, 0);
    chk("coincide_pending", {31'd0, wr_ready}, 0);
    chk("coincide_no_partial", {31'd0, partial}, 0);
    vsync = 1;
    repeat (4) step();
    chk("coincide_still_pending", {31'd0, wr_ready}, 0);
    rd("coincide_old_c0", 5'd5, 5'd0, 1'b1);
    vfall("imgc");
    rd("c_c0", 5'd5, 5'd0, 1'b0);
    rd("c_c4", 5'd5, 5'd4, 1'b1);

    load(0, 9, 32'h0000_0001, 1'b1);
    chk("partial_pulse", {31'd0, partial}, 1);
    step();
    chk("partial_one_cycle", {31'd0, partial}, 0);
    vfall("partial");
    rd("partial_new_c31", 5'd3, 5'd31, 1'b1);
    rd("partial_new_c0", 5'd3, 5'd0, 1'b0);
    rd("partial_stale_c0", 5'd20, 5'd0, 1'b1);
    rd("partial_stale_c31", 5'd20, 5'd31, 1'b0);

    load(0, 3, 32'hFFFF_FFFF, 1'b0);
    reset = 0;
    #1;
    chk("midrst_image_valid", {31'd0, image_valid}, 0);
    chk("midrst_ready", {31'd0, wr_ready}, 1);
    step();
    reset = 1;
    rd("midrst_pixel", 5'd3, 5'd31, 1'b0);

`ifdef SPRITE_LOADER_MIRROR_EN
    load(0, 31, 32'h0000_0001, 1'b1);
    mirror = 1;
    vfall("mirror");
    rd("mirror_c0", 5'd7, 5'd0, 1'b1);
    rd("mirror_c31", 5'd7, 5'd31, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
